// File: rtl/vga_word_scroller.sv
// Frame-synchronous scrolling text source: a 6-character window of MESSAGE, updated at vsync start.
// Optional macro SCROLL_REVERSE_EN adds a dir input that scrolls backwards while high.
module vga_word_scroller #(
  parameter int                   MSG_LEN         = 16,
  parameter logic [8*MSG_LEN-1:0] MESSAGE         = "DANTE FPGA VGA  ",
  parameter int                   FRAMES_PER_STEP = 30,
  parameter bit                   VS_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        pause,
  input  logic        step_req,
`ifdef SCROLL_REVERSE_EN
  input  logic        dir,
`endif
  output logic [47:0] word,
  output logic [7:0]  offset,
  output logic        frame_tick
);

  localparam logic       VS_IDLE  = VS_ACTIVE_LOW;
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] OFS_LAST = 8'(MSG_LEN - 1);
  localparam logic [8:0] LEN9     = 9'(MSG_LEN);

  generate
    if (MSG_LEN < 6 || MSG_LEN > 256) begin : g_bad_len
      $error("vga_word_scroller: MSG_LEN must be within 6..256");
    end
    if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_bad_fps
      $error("vga_word_scroller: FRAMES_PER_STEP must be within 1..255");
    end
  endgenerate

  // offset+k never reaches 2*MSG_LEN, so one conditional subtract replaces the modulo
  function automatic logic [7:0] f_char(input logic [8:0] idx);
    logic [8:0]           idx_wrap;
    logic [8*MSG_LEN-1:0] shifted;
    idx_wrap = (idx >= LEN9) ? idx - LEN9 : idx;
    shifted  = MESSAGE << {idx_wrap, 3'b000};
    return shifted[8*MSG_LEN-1 -: 8];
  endfunction

  function automatic logic [47:0] f_window(input logic [7:0] ofs);
    logic [47:0] win;
    win = '0;
    for (int k = 0; k < 6; k++) begin
      win[47-8*k -: 8] = f_char({1'b0, ofs} + 9'(k));
    end
    return win;
  endfunction

  function automatic logic [7:0] f_advance(input logic [7:0] ofs, input logic rev);
    if (rev) return (ofs == 8'd0) ? OFS_LAST : ofs - 8'd1;
    return (ofs == OFS_LAST) ? 8'd0 : ofs + 8'd1;
  endfunction

  logic        r_vs_q;
  logic        r_armed;
  logic        r_step_pend;
  logic [7:0]  r_cnt;
  logic [7:0]  r_offset_p1;
  logic        r_vld_p1;
  logic [47:0] r_word_p2;
  logic        w_edge;
  logic        w_adv;
  logic        w_rev;
  logic [7:0]  w_cnt_nxt;

`ifdef SCROLL_REVERSE_EN
  assign w_rev = dir;
`else
  assign w_rev = 1'b0;
`endif

  // r_armed masks the first cycle after reset so a sync pulse already in progress is not an edge
  assign w_edge = r_armed & (VS_ACTIVE_LOW ? (~vsync & r_vs_q) : (vsync & ~r_vs_q));

  always_comb begin
    w_adv     = 1'b0;
    w_cnt_nxt = r_cnt;
    if (w_edge) begin
      if (!pause) begin
        if (r_cnt == CNT_LAST) begin
          w_adv     = 1'b1;
          w_cnt_nxt = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end else if (r_step_pend || step_req) begin
        w_adv     = 1'b1;
        w_cnt_nxt = 8'd0;
      end
    end
  end

  // Stage p0: sync edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q  <= VS_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_vs_q  <= vsync;
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_pend <= 1'b0;
    end else if (!pause || w_edge) begin
      r_step_pend <= 1'b0;
    end else if (step_req) begin
      r_step_pend <= 1'b1;
    end
  end

  // Stage p1: frame counter, offset and frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_offset_p1 <= 8'd0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_vld_p1 <= w_edge;
      if (w_adv) r_offset_p1 <= f_advance(r_offset_p1, w_rev);
    end
  end

  // Stage p2: window reload from the settled offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_p2 <= f_window(8'd0);
    end else if (r_vld_p1) begin
      r_word_p2 <= f_window(r_offset_p1);
    end
  end

  assign word       = r_word_p2;
  assign offset     = r_offset_p1;
  assign frame_tick = r_vld_p1;

endmodule

// File: tb/tb_vga_word_scroller.sv
// Directed bench for vga_word_scroller with a frame-tick scoreboard (reverse case when SCROLL_REVERSE_EN is set).
module tb_vga_word_scroller;
  localparam int MSG_LEN = 8;
  localparam int FPS     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vsync = 1'b0;
  logic        pause = 1'b0;
  logic        step_req = 1'b0;
`ifdef SCROLL_REVERSE_EN
  logic        dir = 1'b0;
`endif
  logic [47:0] word;
  logic [7:0]  offset;
  logic        frame_tick;

  vga_word_scroller #(
    .MSG_LEN(MSG_LEN), .MESSAGE("ABCDEFGH"), .FRAMES_PER_STEP(FPS), .VS_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .step_req(step_req),
`ifdef SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .word(word), .offset(offset), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_ticks = 0;
  int          n_edges = 0;
  int          m_off = 0;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  bit          m_dir = 1'b0;
  bit          w_pend = 1'b0;
  logic [47:0] exp_w;
  logic [7:0]  q_off[$];
  logic [47:0] q_word[$];
  string       s = "ABCDEFGH";

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] m_word(input int off);
    logic [47:0] w;
    w = '0;
    for (int k = 0; k < 6; k++) w = {w[39:0], 8'(s[(off + k) % MSG_LEN])};
    return w;
  endfunction

  function automatic int m_step(input int off, input bit rev);
    return rev ? (off + MSG_LEN - 1) % MSG_LEN : (off + 1) % MSG_LEN;
  endfunction

  task automatic do_edge(input int low_cycles);
    @(negedge clk);
    vsync = 1'b0;
    n_edges++;
    if (!pause) begin
      if (m_cnt == FPS - 1) begin
        m_off = m_step(m_off, m_dir);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_pend) begin
      m_off  = m_step(m_off, m_dir);
      m_cnt  = 0;
      m_pend = 1'b0;
    end
    q_off.push_back(8'(m_off));
    q_word.push_back(m_word(m_off));
    repeat (low_cycles) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_step();
    @(negedge clk);
    step_req = 1'b1;
    if (pause) m_pend = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic set_pause(input logic p);
    @(negedge clk);
    pause = p;
    if (!p) m_pend = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    check({tag, "_word"}, word, "ABCDEF");
    check({tag, "_offset"}, 48'(offset), 48'd0);
    check({tag, "_tick"}, 48'(frame_tick), 48'd0);
    m_off = 0; m_cnt = 0; m_pend = 1'b0;
    q_off.delete();
    q_word.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // scoreboard monitor: offset checked with the tick, word one cycle later
  initial begin
    forever begin
      @(negedge clk);
      if (w_pend) begin
        check("word_after_tick", word, exp_w);
        w_pend = 1'b0;
      end
      if (frame_tick === 1'b1) begin
        n_ticks++;
        if (q_off.size() == 0) begin
          check("spurious_tick", 48'(frame_tick), 48'd0);
        end else begin
          check("offset_at_tick", 48'(offset), 48'(q_off.pop_front()));
          exp_w  = q_word.pop_front();
          w_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    // asynchronous reset with vsync held low through release
    #5 rst_n = 1'b0;
    #1;
    check("rst_word", word, "ABCDEF");
    check("rst_offset", 48'(offset), 48'd0);
    check("rst_tick", 48'(frame_tick), 48'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_tick_after_release", 48'(n_ticks), 48'd0);
    vsync = 1'b1;
    repeat (3) @(negedge clk);

    // basic step
    repeat (2) do_edge(3);
    check("basic_offset", 48'(offset), 48'd1);
    check("basic_word", word, "BCDEFG");

    // wrap
    repeat (10) do_edge(3);
    check("wrap_offset6", 48'(offset), 48'd6);
    check("wrap_word6", word, "GHABCD");
    repeat (4) do_edge(3);
    check("wrap_offset0", 48'(offset), 48'd0);
    check("wrap_word0", word, "ABCDEF");

    // pause holds, including one long sync pulse
    set_pause(1'b1);
    repeat (9) do_edge(3);
    do_edge(40);
    check("pause_offset", 48'(offset), 48'd0);
    check("pause_word", word, "ABCDEF");

    // two step requests in one frame give one advance and clear cnt
    do_step();
    do_step();
    do_edge(3);
    check("step_offset", 48'(offset), 48'd1);
    set_pause(1'b0);
    do_edge(3);
    check("step_cnt0_hold", 48'(offset), 48'd1);
    do_edge(3);
    check("step_cnt0_adv", 48'(offset), 48'd2);
    check("step_word", word, "CDEFGH");

    // step_req ignored while running
    do_step();
    do_edge(3);
    check("run_step_ignored", 48'(offset), 48'd2);
    do_edge(3);
    check("run_adv", 48'(offset), 48'd3);

    // pending step dropped when pause deasserts; leaves cnt=1
    set_pause(1'b1);
    do_step();
    set_pause(1'b0);
    do_edge(3);
    check("pend_cleared", 48'(offset), 48'd3);

    // reset mid-count
    do_reset("midrst");
    do_edge(3);
    check("midrst_first_edge", 48'(offset), 48'd0);
    do_edge(3);
    check("midrst_second_edge", 48'(offset), 48'd1);
    check("midrst_word", word, "BCDEFG");

`ifdef SCROLL_REVERSE_EN
    do_reset("revrst");
    dir   = 1'b1;
    m_dir = 1'b1;
    repeat (2) do_edge(3);
    check("rev_offset", 48'(offset), 48'd7);
    check("rev_word", word, "HABCDE");
`endif

    repeat (3) @(negedge clk);
    check("tick_count", 48'(n_ticks), 48'(n_edges));
    check("queue_drained", 48'(q_off.size()), 48'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
